// File: rtl/outer1bits_walker_pkg.sv
// outer1bits_walker_pkg: shared width default, FSM states and span-mask helper for the walker.
package outer1bits_pkg;
  localparam int WIDTH_DEF = 4;
  typedef enum logic {IDLE, RUN} state_t;
  function automatic logic [63:0] span_mask(input int hi, input int lo);
    logic [63:0] m;
    for (int i = 0; i < 64; i++) m[i] = (i >= lo) && (i <= hi);
    return m;
  endfunction
endpackage

// File: rtl/outer1bits_walker_if.sv
// outer1bits_walker_if: pair input stream, index output stream, mask and error for the walker.
interface outer1bits_walker_if #(
  parameter int WIDTH = outer1bits_pkg::WIDTH_DEF,
  localparam int IDX_W = $clog2(WIDTH)
);
  logic             data_val_i;
  logic [WIDTH-1:0] data_left_i;
  logic [WIDTH-1:0] data_right_i;
  logic             data_ready_o;
  logic             idx_val_o;
  logic [IDX_W-1:0] idx_o;
  logic             idx_last_o;
  logic             idx_ready_i;
  logic [WIDTH-1:0] mask_o;
  logic             err_o;
  modport master (
    output data_val_i, data_left_i, data_right_i, idx_ready_i,
    input  data_ready_o, idx_val_o, idx_o, idx_last_o, mask_o, err_o
  );
  modport slave (
    input  data_val_i, data_left_i, data_right_i, idx_ready_i,
    output data_ready_o, idx_val_o, idx_o, idx_last_o, mask_o, err_o
  );
endinterface

// File: rtl/outer1bits_walker_onehot2idx.sv
// onehot2idx: priority encoder; HIGH_FIRST picks the highest set bit, otherwise the lowest.
module onehot2idx #(
  parameter int WIDTH = 4,
  parameter bit HIGH_FIRST = 1'b1,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx
);
  always_comb begin
    idx = '0;
    for (int i = 0; i < WIDTH; i++)
      if (vec[HIGH_FIRST ? i : WIDTH-1-i]) idx = IDX_W'(HIGH_FIRST ? i : WIDTH-1-i);
  end
endmodule

// File: rtl/outer1bits_walker.sv
// outer1bits_walker: streams every bit index in [right, left] of an outer-ones pair, one per cycle.
// Define OUTER1BITS_WALKER_CHECK_EN to reject illegal pairs with an err_o pulse.
module outer1bits_walker
  import outer1bits_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input logic clk_i,
  input logic srst_i,
  outer1bits_walker_if.slave bus
);
  logic [IDX_W-1:0] l_idx, r_idx, lo, hi, cur, hi_q;
  logic [WIDTH-1:0] mask;
  logic lz, rz, zero, skip, accept, ready, idx_val, idx_last;
  state_t state;
  onehot2idx #(.WIDTH(WIDTH), .HIGH_FIRST(1'b1)) u_left (.vec(bus.data_left_i), .idx(l_idx));
  onehot2idx #(.WIDTH(WIDTH), .HIGH_FIRST(1'b0)) u_right (.vec(bus.data_right_i), .idx(r_idx));
  assign lz = bus.data_left_i == '0;
  assign rz = bus.data_right_i == '0;
  assign zero = lz & rz;
  assign accept = bus.data_val_i & ready;
  // Half-zero or reversed pairs collapse to a single beat at the surviving index.
  assign lo = rz ? l_idx : r_idx;
  assign hi = (lz || rz || l_idx < r_idx) ? lo : l_idx;
`ifdef OUTER1BITS_WALKER_CHECK_EN
  logic ohl, ohr, bad, err;
  assign ohl = !lz && (bus.data_left_i & (bus.data_left_i - 1'b1)) == '0;
  assign ohr = !rz && (bus.data_right_i & (bus.data_right_i - 1'b1)) == '0;
  assign bad = !zero && !(ohl && ohr && l_idx >= r_idx);
  assign skip = zero | bad;
  always_ff @(posedge clk_i) err <= !srst_i && accept && bad;
  assign bus.err_o = err;
`else
  assign skip = zero;
  assign bus.err_o = 1'b0;
`endif
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state <= IDLE;
      ready <= 1'b0;
      idx_val <= 1'b0;
      idx_last <= 1'b0;
      cur <= '0;
      hi_q <= '0;
      mask <= '0;
    end else if (state == IDLE) begin
      ready <= 1'b1;
      if (accept) begin
        mask <= skip ? '0 : WIDTH'(span_mask(int'(hi), int'(lo)));
        if (!skip) begin
          state <= RUN;
          ready <= 1'b0;
          idx_val <= 1'b1;
          cur <= lo;
          hi_q <= hi;
          idx_last <= lo == hi;
        end
      end
    end else if (bus.idx_ready_i) begin
      if (idx_last) begin
        state <= IDLE;
        ready <= 1'b1;
        idx_val <= 1'b0;
        idx_last <= 1'b0;
      end else begin
        cur <= cur + IDX_W'(1);
        idx_last <= cur + IDX_W'(1) == hi_q;
      end
    end
  end
  assign bus.data_ready_o = ready;
  assign bus.idx_val_o = idx_val;
  assign bus.idx_o = cur;
  assign bus.idx_last_o = idx_last;
  assign bus.mask_o = mask;
endmodule

// File: tb/tb_outer1bits_walker.sv
// tb_outer1bits_walker: scenario tasks with a beat scoreboard popped on every index handshake.
module tb_outer1bits_walker;
  typedef struct packed {logic [1:0] idx; logic last;} beat_t;
  logic clk = 1'b0;
  logic srst = 1'b1;
  int tests = 0;
  int fails = 0;
  beat_t q[$];
  always #5 clk = ~clk;
  outer1bits_walker_if #(.WIDTH(4)) bus ();
  outer1bits_walker dut (.clk_i(clk), .srst_i(srst), .bus(bus.slave));

  always @(negedge clk) begin
    if (!srst && bus.idx_val_o && bus.idx_ready_i) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL beat_extra actual idx=%0d last=%b required none", bus.idx_o, bus.idx_last_o);
      end else begin
        beat_t e;
        e = q.pop_front();
        if ({bus.idx_o, bus.idx_last_o} !== e) begin
          fails++;
          $display("FAIL beat actual idx=%0d last=%b required idx=%0d last=%b",
                   bus.idx_o, bus.idx_last_o, e.idx, e.last);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] idx, input logic last);
    beat_t b;
    b.idx = idx;
    b.last = last;
    q.push_back(b);
  endtask

  task automatic send(input logic [3:0] l, input logic [3:0] r);
    int n = 0;
    while (bus.data_ready_o !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    tests++;
    if (bus.data_ready_o !== 1'b1) begin
      fails++;
      $display("FAIL send_ready actual=%b required=1", bus.data_ready_o);
    end
    bus.data_val_i = 1'b1;
    bus.data_left_i = l;
    bus.data_right_i = r;
    tick();
    bus.data_val_i = 1'b0;
    bus.data_left_i = '0;
    bus.data_right_i = '0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (bus.idx_val_o === 1'b1 && n < 30) begin
      tick();
      n++;
    end
    tests++;
    if (bus.idx_val_o !== 1'b0 || bus.data_ready_o !== 1'b1 || q.size() != 0) begin
      fails++;
      $display("FAIL %s_idle actual val=%b ready=%b pending=%0d required val=0 ready=1 pending=0",
               name, bus.idx_val_o, bus.data_ready_o, q.size());
    end
  endtask

  task automatic test_reset();
    tick();
    tick();
    tests++;
    if ({bus.data_ready_o, bus.idx_val_o, bus.idx_o, bus.idx_last_o, bus.mask_o, bus.err_o} !== 10'b0) begin
      fails++;
      $display("FAIL reset_vals actual ready=%b val=%b idx=%0d last=%b mask=%b err=%b required all 0",
               bus.data_ready_o, bus.idx_val_o, bus.idx_o, bus.idx_last_o, bus.mask_o, bus.err_o);
    end
    srst = 1'b0;
    tick();
    tests++;
    if (bus.data_ready_o !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready actual=%b required=1", bus.data_ready_o);
    end
  endtask

  task automatic test_full_span();
    for (int i = 0; i < 4; i++) push(2'(i), i == 3);
    send(4'b1000, 4'b0001);
    tests++;
    if (bus.mask_o !== 4'b1111 || bus.idx_val_o !== 1'b1) begin
      fails++;
      $display("FAIL full_mask actual mask=%b val=%b required mask=1111 val=1", bus.mask_o, bus.idx_val_o);
    end
    tick();
    tick();
    tick();
    tests++;
    if (bus.data_ready_o !== 1'b0 || bus.idx_o !== 2'd3 || bus.idx_last_o !== 1'b1) begin
      fails++;
      $display("FAIL full_last actual ready=%b idx=%0d last=%b required ready=0 idx=3 last=1",
               bus.data_ready_o, bus.idx_o, bus.idx_last_o);
    end
    tick();
    wait_idle("full");
  endtask

  task automatic test_single();
    push(2'd2, 1'b1);
    send(4'b0100, 4'b0100);
    tests++;
    if (bus.mask_o !== 4'b0100 || bus.idx_last_o !== 1'b1) begin
      fails++;
      $display("FAIL single actual mask=%b last=%b required mask=0100 last=1", bus.mask_o, bus.idx_last_o);
    end
    tick();
    wait_idle("single");
  endtask

  task automatic test_zero();
    send(4'b0000, 4'b0000);
    tests++;
    if (bus.idx_val_o !== 1'b0 || bus.mask_o !== 4'b0000 || bus.data_ready_o !== 1'b1) begin
      fails++;
      $display("FAIL zero actual val=%b mask=%b ready=%b required val=0 mask=0000 ready=1",
               bus.idx_val_o, bus.mask_o, bus.data_ready_o);
    end
    tick();
    tests++;
    if (bus.idx_val_o !== 1'b0) begin
      fails++;
      $display("FAIL zero_nobeat actual val=%b required=0", bus.idx_val_o);
    end
  endtask

  task automatic test_stall();
    push(2'd1, 1'b0);
    push(2'd2, 1'b0);
    push(2'd3, 1'b1);
    send(4'b1000, 4'b0010);
    tick();
    bus.idx_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (bus.idx_val_o !== 1'b1 || bus.idx_o !== 2'd2 || bus.idx_last_o !== 1'b0) begin
        fails++;
        $display("FAIL stall_hold actual val=%b idx=%0d last=%b required val=1 idx=2 last=0",
                 bus.idx_val_o, bus.idx_o, bus.idx_last_o);
      end
    end
    bus.idx_ready_i = 1'b1;
    tick();
    wait_idle("stall");
  endtask

  task automatic test_reset_mid();
    push(2'd0, 1'b0);
    send(4'b1000, 4'b0001);
    tick();
    srst = 1'b1;
    tick();
    tests++;
    if (bus.idx_val_o !== 1'b0 || bus.mask_o !== 4'b0000 || bus.data_ready_o !== 1'b0) begin
      fails++;
      $display("FAIL midreset actual val=%b mask=%b ready=%b required val=0 mask=0000 ready=0",
               bus.idx_val_o, bus.mask_o, bus.data_ready_o);
    end
    srst = 1'b0;
    tick();
    wait_idle("midreset");
  endtask

  task automatic test_back_to_back();
    push(2'd0, 1'b0);
    push(2'd1, 1'b1);
    send(4'b0010, 4'b0001);
    push(2'd3, 1'b1);
    send(4'b1000, 4'b1000);
    tests++;
    if (bus.mask_o !== 4'b1000) begin
      fails++;
      $display("FAIL b2b_mask actual=%b required=1000", bus.mask_o);
    end
    tick();
    wait_idle("b2b");
  endtask

  task automatic test_illegal(input logic [3:0] l, input logic [3:0] r, input logic [1:0] fb);
`ifdef OUTER1BITS_WALKER_CHECK_EN
    send(l, r);
    tests++;
    if (bus.err_o !== 1'b1 || bus.idx_val_o !== 1'b0 || bus.mask_o !== 4'b0000) begin
      fails++;
      $display("FAIL illegal_err actual err=%b val=%b mask=%b required err=1 val=0 mask=0000",
               bus.err_o, bus.idx_val_o, bus.mask_o);
    end
    tick();
    tests++;
    if (bus.err_o !== 1'b0 || bus.idx_val_o !== 1'b0) begin
      fails++;
      $display("FAIL illegal_pulse actual err=%b val=%b required err=0 val=0", bus.err_o, bus.idx_val_o);
    end
`else
    logic [3:0] m;
    m = 4'b0001 << fb;
    push(fb, 1'b1);
    send(l, r);
    tests++;
    if (bus.mask_o !== m || bus.err_o !== 1'b0 || bus.idx_last_o !== 1'b1) begin
      fails++;
      $display("FAIL illegal_fallback actual mask=%b err=%b last=%b required mask=%b err=0 last=1",
               bus.mask_o, bus.err_o, bus.idx_last_o, m);
    end
    tick();
    wait_idle("illegal");
`endif
  endtask

  initial begin
    bus.data_val_i = 1'b0;
    bus.data_left_i = '0;
    bus.data_right_i = '0;
    bus.idx_ready_i = 1'b1;
    test_reset();
    test_full_span();
    test_single();
    test_zero();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    test_illegal(4'b0001, 4'b1000, 2'd3);
    test_illegal(4'b0100, 4'b0000, 2'd2);
    test_illegal(4'b0000, 4'b0010, 2'd1);
    tick();
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL leftover actual=%0d required=0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
